// File: rtl/dc_bsp_pkg.sv
// rtl/dc_bsp_pkg.sv - shared BSP constants and types used by the ASP interrupt aggregator
package dc_bsp_pkg;

  localparam logic [2:0] BSP_IRQ_EDGE_MASK     = 3'b101;
  localparam int         BSP_IRQ_HOLDOFF_WIDTH = 16;

  localparam logic [1:0] IRQ_CSR_PENDING = 2'd0;
  localparam logic [1:0] IRQ_CSR_ENABLE  = 2'd1;
  localparam logic [1:0] IRQ_CSR_RAW     = 2'd2;
  localparam logic [1:0] IRQ_CSR_HOLDOFF = 2'd3;

  typedef enum logic {
    IRQ_HOLD_IDLE = 1'b0,
    IRQ_HOLD_HOLD = 1'b1
  } irq_hold_state_e;

endpackage

// File: rtl/asp_irq_aggregator_if.sv
// rtl/asp_irq_aggregator_if.sv - AVMM CSR window bundle for the interrupt aggregator
interface asp_irq_aggregator_if #(
  parameter int CSR_DATA_WIDTH = 64
);

  logic [1:0]                csr_address;
  logic                      csr_read;
  logic                      csr_write;
  logic [CSR_DATA_WIDTH-1:0] csr_writedata;
  logic [CSR_DATA_WIDTH-1:0] csr_readdata;
  logic                      csr_readdatavalid;
  logic                      csr_waitrequest;

  modport master (
    output csr_address, csr_read, csr_write, csr_writedata,
    input  csr_readdata, csr_readdatavalid, csr_waitrequest
  );

  modport slave (
    input  csr_address, csr_read, csr_write, csr_writedata,
    output csr_readdata, csr_readdatavalid, csr_waitrequest
  );

endinterface

// File: rtl/asp_irq_source_latch.sv
// rtl/asp_irq_source_latch.sv - per-source edge/level detect with a write-1-to-clear pending bit
module asp_irq_source_latch #(
  parameter bit IS_EDGE = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic irq_in,
  input  logic irq_in_q,
  input  logic clr,
  output logic pending_next,
  output logic pending
);

  logic set_evt;
  logic pending_q;
  logic pending_d;

  // A new request beats a same-cycle clear; for level sources this also
  // keeps the bit set for as long as the input stays high.
  always_comb begin
    set_evt   = IS_EDGE ? (irq_in & ~irq_in_q) : irq_in;
    pending_d = set_evt | (pending_q & ~clr);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign pending_next = pending_d;
  assign pending      = pending_q;

endmodule

// File: rtl/asp_irq_aggregator.sv
// rtl/asp_irq_aggregator.sv - pending/enable interrupt aggregator with re-arm holdoff and CSR window
module asp_irq_aggregator
  import dc_bsp_pkg::*;
#(
  parameter int                       NUM_IRQ        = 3,
  parameter int                       NUM_LINES      = 4,
  parameter logic [NUM_IRQ-1:0]       EDGE_MASK      = BSP_IRQ_EDGE_MASK,
  parameter logic [NUM_IRQ-1:0]       ENABLE_RESET   = '1,
  parameter int                       HOLDOFF_WIDTH  = BSP_IRQ_HOLDOFF_WIDTH,
  parameter logic [HOLDOFF_WIDTH-1:0] HOLDOFF_RESET  = '0,
  parameter int                       CSR_DATA_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_IRQ-1:0]   irq_in,
  output logic [NUM_LINES-1:0] irq_out,
  output logic                 irq_any,
  asp_irq_aggregator_if.slave  csr
);

  logic [NUM_IRQ-1:0]        irq_in_q;
  logic [NUM_IRQ-1:0]        pending_q;
  logic [NUM_IRQ-1:0]        pending_d;
  logic [NUM_IRQ-1:0]        pending_clr;
  logic [NUM_IRQ-1:0]        enable_q;
  logic [NUM_IRQ-1:0]        enable_d;
  logic [HOLDOFF_WIDTH-1:0]  holdoff_q;
  logic [HOLDOFF_WIDTH-1:0]  holdoff_d;
  logic [HOLDOFF_WIDTH-1:0]  cnt_q;
  logic [HOLDOFF_WIDTH-1:0]  cnt_d;
  irq_hold_state_e           state_q;
  irq_hold_state_e           state_d;
  logic [NUM_LINES-1:0]      irq_out_q;
  logic [NUM_LINES-1:0]      irq_out_d;
  logic                      irq_any_q;
  logic                      irq_any_d;
  logic [CSR_DATA_WIDTH-1:0] readdata_q;
  logic [CSR_DATA_WIDTH-1:0] readdata_d;
  logic                      rdv_q;
  logic                      rdv_d;
  logic                      pend_wr;
  logic                      en_wr;
  logic                      hold_wr;
  logic                      unused_wdata;

  assign pend_wr      = csr.csr_write && (csr.csr_address == IRQ_CSR_PENDING);
  assign en_wr        = csr.csr_write && (csr.csr_address == IRQ_CSR_ENABLE);
  assign hold_wr      = csr.csr_write && (csr.csr_address == IRQ_CSR_HOLDOFF);
  assign pending_clr  = pend_wr ? csr.csr_writedata[NUM_IRQ-1:0] : '0;
  assign unused_wdata = ^csr.csr_writedata;

  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_src
    asp_irq_source_latch #(
      .IS_EDGE (EDGE_MASK[i])
    ) u_latch (
      .clk          (clk),
      .reset_n      (reset_n),
      .irq_in       (irq_in[i]),
      .irq_in_q     (irq_in_q[i]),
      .clr          (pending_clr[i]),
      .pending_next (pending_d[i]),
      .pending      (pending_q[i])
    );
  end

  always_comb begin
    enable_d  = en_wr   ? csr.csr_writedata[NUM_IRQ-1:0]       : enable_q;
    holdoff_d = hold_wr ? csr.csr_writedata[HOLDOFF_WIDTH-1:0] : holdoff_q;
  end

  // Holdoff arms only when software has just drained every enabled source;
  // the running count ignores later HOLDOFF writes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IRQ_HOLD_IDLE: begin
        if (pend_wr && ((pending_d & enable_d) == '0) && (holdoff_q != '0)) begin
          state_d = IRQ_HOLD_HOLD;
          cnt_d   = holdoff_q;
        end
      end
      IRQ_HOLD_HOLD: begin
        cnt_d = cnt_q - HOLDOFF_WIDTH'(1);
        if (cnt_q == HOLDOFF_WIDTH'(1)) begin
          state_d = IRQ_HOLD_IDLE;
        end
      end
      default: begin
        state_d = IRQ_HOLD_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    irq_out_d = '0;
    if (state_q == IRQ_HOLD_IDLE) begin
      irq_out_d[NUM_IRQ-1:0] = pending_q & enable_q;
    end
    irq_any_d = |irq_out_d;
  end

  // Reads see register contents from before any write in the same cycle.
  always_comb begin
    readdata_d = '0;
    rdv_d      = csr.csr_read;
    if (csr.csr_read) begin
      case (csr.csr_address)
        IRQ_CSR_PENDING: readdata_d[NUM_IRQ-1:0]       = pending_q;
        IRQ_CSR_ENABLE:  readdata_d[NUM_IRQ-1:0]       = enable_q;
        IRQ_CSR_RAW:     readdata_d[NUM_IRQ-1:0]       = irq_in_q;
        IRQ_CSR_HOLDOFF: readdata_d[HOLDOFF_WIDTH-1:0] = holdoff_q;
        default:         readdata_d                    = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_in_q   <= '0;
      enable_q   <= ENABLE_RESET;
      holdoff_q  <= HOLDOFF_RESET;
      cnt_q      <= '0;
      state_q    <= IRQ_HOLD_IDLE;
      irq_out_q  <= '0;
      irq_any_q  <= 1'b0;
      readdata_q <= '0;
      rdv_q      <= 1'b0;
    end else begin
      irq_in_q   <= irq_in;
      enable_q   <= enable_d;
      holdoff_q  <= holdoff_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      irq_out_q  <= irq_out_d;
      irq_any_q  <= irq_any_d;
      readdata_q <= readdata_d;
      rdv_q      <= rdv_d;
    end
  end

  assign irq_out               = irq_out_q;
  assign irq_any               = irq_any_q;
  assign csr.csr_readdata      = readdata_q;
  assign csr.csr_readdatavalid = rdv_q;
  assign csr.csr_waitrequest   = 1'b0;

endmodule

// File: tb/tb_asp_irq_aggregator.sv
// tb/tb_asp_irq_aggregator.sv - scoreboard bench for the ASP interrupt aggregator
module tb_asp_irq_aggregator;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [2:0] irq_in = '0;
  logic [3:0] irq_out;
  logic       irq_any;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       name;
    logic [63:0] data;
    logic [3:0]  irq;
  } exp_t;

  exp_t sb[$];

  asp_irq_aggregator_if #(.CSR_DATA_WIDTH(64)) csr_if ();

  asp_irq_aggregator #(
    .NUM_IRQ        (3),
    .NUM_LINES      (4),
    .EDGE_MASK      (3'b101),
    .ENABLE_RESET   (3'b111),
    .HOLDOFF_WIDTH  (16),
    .HOLDOFF_RESET  (16'd0),
    .CSR_DATA_WIDTH (64)
  ) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .irq_in  (irq_in),
    .irq_out (irq_out),
    .irq_any (irq_any),
    .csr     (csr_if.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every returned read is matched against the oldest expectation,
  // together with the interrupt lines visible in that same cycle.
  always @(negedge clk) begin : mon
    exp_t e;
    if (reset_n && csr_if.csr_readdatavalid) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_readdatavalid: got 1 expected 0");
      end else begin
        e = sb.pop_front();
        check({e.name, "_data"}, csr_if.csr_readdata, e.data);
        check({e.name, "_irq"}, {60'd0, irq_out}, {60'd0, e.irq});
        check({e.name, "_any"}, {63'd0, irq_any}, {63'd0, |e.irq});
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic rd(input logic [1:0] a, input logic [63:0] d, input logic [3:0] irq, input string name);
    csr_if.csr_read    = 1'b1;
    csr_if.csr_address = a;
    sb.push_back('{name, d, irq});
    @(negedge clk);
    csr_if.csr_read    = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [63:0] d);
    csr_if.csr_write     = 1'b1;
    csr_if.csr_address   = a;
    csr_if.csr_writedata = d;
    @(negedge clk);
    csr_if.csr_write     = 1'b0;
  endtask

  task automatic rdwr(input logic [1:0] a, input logic [63:0] wd, input logic [63:0] d,
                      input logic [3:0] irq, input string name);
    csr_if.csr_read      = 1'b1;
    csr_if.csr_write     = 1'b1;
    csr_if.csr_address   = a;
    csr_if.csr_writedata = wd;
    sb.push_back('{name, d, irq});
    @(negedge clk);
    csr_if.csr_read      = 1'b0;
    csr_if.csr_write     = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    csr_if.csr_address   = '0;
    csr_if.csr_read      = 1'b0;
    csr_if.csr_write     = 1'b0;
    csr_if.csr_writedata = '0;
    repeat (3) tick();
    reset_n = 1'b1;
    #1;
    check("rst_irq_out", {60'd0, irq_out}, 64'd0);
    check("rst_irq_any", {63'd0, irq_any}, 64'd0);
    check("rst_rdv", {63'd0, csr_if.csr_readdatavalid}, 64'd0);
    check("rst_waitrequest", {63'd0, csr_if.csr_waitrequest}, 64'd0);
    tick();

    rd(2'd0, 64'd0, 4'b0000, "rst_pending");
    rd(2'd1, 64'd7, 4'b0000, "rst_enable");
    rd(2'd2, 64'd0, 4'b0000, "rst_raw");
    rd(2'd3, 64'd0, 4'b0000, "rst_holdoff");

    // Edge source 0, one-cycle pulse, then W1C.
    irq_in = 3'b001;
    tick();
    irq_in = 3'b000;
    rd(2'd0, 64'd1, 4'b0001, "edge_pend");
    wr(2'd0, 64'd1);
    rd(2'd0, 64'd0, 4'b0000, "edge_clr");

    // Level source 1: W1C ignored while high, effective once low.
    irq_in = 3'b010;
    tick();
    wr(2'd0, 64'd2);
    rd(2'd0, 64'd2, 4'b0010, "lvl_hold");
    rd(2'd2, 64'd2, 4'b0010, "lvl_raw");
    irq_in = 3'b000;
    wr(2'd0, 64'd2);
    rd(2'd0, 64'd0, 4'b0000, "lvl_clr");

    // Pending latches while disabled; enabling raises the line.
    wr(2'd1, 64'd0);
    irq_in = 3'b100;
    tick();
    irq_in = 3'b000;
    rd(2'd0, 64'd4, 4'b0000, "dis_pend");
    wr(2'd1, 64'd4);
    rd(2'd0, 64'd4, 4'b0100, "en_late");
    rd(2'd1, 64'd4, 4'b0100, "en_rd");

    // Holdoff of 10 cycles after draining the last pending source.
    wr(2'd3, 64'd10);
    rd(2'd3, 64'd10, 4'b0100, "hold_rd");
    wr(2'd1, 64'd7);
    wr(2'd0, 64'd4);
    for (int j = 1; j <= 11; j++) begin
      if (j == 1) irq_in = 3'b001;
      rd(2'd0, (j == 1) ? 64'd0 : 64'd1, (j <= 10) ? 4'b0000 : 4'b0001,
         $sformatf("hold_%0d", j));
      if (j == 1) irq_in = 3'b000;
    end

    // Reset in the middle of a holdoff window.
    wr(2'd0, 64'd1);
    tick();
    tick();
    reset_n = 1'b0;
    irq_in  = 3'b011;
    #1;
    check("midhold_rst_irq_out", {60'd0, irq_out}, 64'd0);
    check("midhold_rst_rdv", {63'd0, csr_if.csr_readdatavalid}, 64'd0);
    tick();
    tick();
    reset_n = 1'b1;
    rd(2'd0, 64'd0, 4'b0000, "rel_pend0");
    rd(2'd0, 64'd3, 4'b0011, "rel_pend");
    rd(2'd3, 64'd0, 4'b0011, "rel_holdoff");
    irq_in = 3'b000;
    wr(2'd0, 64'd3);
    rd(2'd0, 64'd0, 4'b0000, "post_clr");

    // Edge arriving in the same cycle as its W1C.
    irq_in = 3'b001;
    tick();
    irq_in = 3'b000;
    tick();
    irq_in = 3'b001;
    wr(2'd0, 64'd1);
    irq_in = 3'b000;
    rd(2'd0, 64'd1, 4'b0001, "set_wins");

    // Same-cycle read and write; upper write bits are dropped.
    rdwr(2'd3, 64'd5, 64'd0, 4'b0001, "rw_old");
    rd(2'd3, 64'd5, 4'b0001, "rw_new");
    wr(2'd1, 64'hFFFF_FFFF_FFFF_FFF8);
    rd(2'd1, 64'd0, 4'b0000, "en_upper");
    wr(2'd3, 64'hABCD_0001_0003);
    rd(2'd3, 64'd3, 4'b0000, "hold_upper");

    repeat (3) tick();
    check("sb_drain", sb.size(), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
